// File: rtl/soc_start_sequencer.sv
// Avalon-MM sequencer: GO launches a one-cycle engine start, then waits for done/timeout/abort.
// Tracks operation length in LAST and raises a maskable level irq from the sticky status bits.
module soc_start_sequencer #(
  parameter int              CNT_W       = 16,
  parameter logic [CNT_W-1:0] DEF_TIMEOUT = CNT_W'(1000)
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        eng_start,
  output logic        eng_abort,
  input  logic        eng_done,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_timeout;
  logic [CNT_W-1:0] r_last;
  logic             r_irq_en;
  logic             r_done;
  logic             r_tmo;
  logic             r_abt;
  logic             r_ovr;
  logic             r_eng_abort;
  logic             r_irq;

  logic w_wr;
  logic w_wr_ctrl;
  logic w_wr_stat;
  logic w_wr_tmo;
  logic w_go;
  logic w_abort;
  logic w_tmo_hit;
  logic w_launch;
  logic w_set_done;
  logic w_set_tmo;
  logic w_set_abt;
  logic w_eng_start;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr && (address == 2'd0);
  assign w_wr_stat = w_wr && (address == 2'd1);
  assign w_wr_tmo  = w_wr && (address == 2'd2);
  assign w_go      = w_wr_ctrl & writedata[0];
  assign w_abort   = w_wr_ctrl & writedata[2];
  assign w_tmo_hit = (r_timeout != '0) && (r_cnt == r_timeout);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Abort beats done, and done beats timeout, when they coincide.
  always_comb begin
    w_next      = r_state;
    w_launch    = 1'b0;
    w_set_done  = 1'b0;
    w_set_tmo   = 1'b0;
    w_set_abt   = 1'b0;
    w_eng_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go && !w_abort) begin
          w_next   = S_START;
          w_launch = 1'b1;
        end
      end
      S_START: begin
        w_eng_start = 1'b1;
        if (w_abort) begin
          w_next    = S_IDLE;
          w_set_abt = 1'b1;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_abort) begin
          w_next    = S_IDLE;
          w_set_abt = 1'b1;
        end else if (eng_done) begin
          w_next     = S_IDLE;
          w_set_done = 1'b1;
        end else if (w_tmo_hit) begin
          w_next    = S_IDLE;
          w_set_tmo = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign eng_start = w_eng_start;
  assign busy      = (r_state != S_IDLE);
  assign eng_abort = r_eng_abort;
  assign irq       = r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_timeout   <= DEF_TIMEOUT;
      r_last      <= '0;
      r_irq_en    <= 1'b0;
      r_done      <= 1'b0;
      r_tmo       <= 1'b0;
      r_abt       <= 1'b0;
      r_ovr       <= 1'b0;
      r_eng_abort <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (r_state == S_START)                        r_cnt <= CNT_W'(1);
      else if (r_state == S_WAIT && r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
      if (w_set_done) r_last <= r_cnt;
      if (w_wr_tmo)   r_timeout <= writedata[CNT_W-1:0];
      if (w_wr_ctrl)  r_irq_en <= writedata[1];
      // Sticky bits: a set in the same cycle as a W1C clear wins.
      r_done      <= w_set_done | (r_done & ~((w_wr_stat & writedata[1]) | w_launch));
      r_tmo       <= w_set_tmo  | (r_tmo  & ~((w_wr_stat & writedata[2]) | w_launch));
      r_abt       <= w_set_abt  | (r_abt  & ~((w_wr_stat & writedata[3]) | w_launch));
      r_ovr       <= (w_go & busy) | (r_ovr & ~(w_wr_stat & writedata[4]));
      r_eng_abort <= w_set_tmo | w_set_abt;
      r_irq       <= r_irq_en & (r_done | r_tmo | r_abt);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1] = r_irq_en;
      2'd1: readdata[4:0] = {r_ovr, r_abt, r_tmo, r_done, busy};
      2'd2: readdata[CNT_W-1:0] = r_timeout;
      2'd3: readdata[CNT_W-1:0] = r_last;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_start_sequencer.sv
// Bench for soc_start_sequencer: directed stimulus queues expected values; a negedge monitor checks them.
module tb_soc_start_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        eng_start;
  logic        eng_abort;
  logic        eng_done;
  logic        eng_done_eng = 1'b0;
  logic        eng_done_man = 1'b0;
  logic        busy;
  logic        irq;

  assign eng_done = eng_done_eng | eng_done_man;

  soc_start_sequencer #(.CNT_W(16), .DEF_TIMEOUT(16'd1000)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_done(eng_done),
    .busy(busy), .irq(irq)
  );

  always #5 clk = ~clk;

  localparam int C_RD = 0, C_IRQ = 1, C_BUSY = 2, C_NST = 3, C_NAB = 4, C_ST = 5, C_AB = 6;

  typedef struct {
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  logic chk_vld = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_starts = 0;
  int   n_aborts = 0;
  int   eng_delay = 0;

  // Monitor: pulse counters first, then any pending scoreboard comparison.
  always @(negedge clk) begin
    logic [31:0] act;
    exp_t        e;
    if (eng_start) n_starts++;
    if (eng_abort) n_aborts++;
    if (chk_vld) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_empty: check presented with no expected entry");
      end else begin
        e = sb.pop_front();
        case (e.sel)
          C_RD:    act = readdata;
          C_IRQ:   act = {31'd0, irq};
          C_BUSY:  act = {31'd0, busy};
          C_NST:   act = n_starts;
          C_NAB:   act = n_aborts;
          C_ST:    act = {31'd0, eng_start};
          C_AB:    act = {31'd0, eng_abort};
          default: act = 'x;
        endcase
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.exp, $time);
        end
      end
    end
  end

  // Engine model: raises done for one cycle eng_delay cycles after the start pulse (0 = never).
  initial begin
    forever begin
      int d;
      @(negedge clk);
      if (eng_start && eng_delay > 0) begin
        d = eng_delay;
        repeat (d) @(posedge clk);
        #1 eng_done_eng = 1'b1;
        @(posedge clk);
        #1 eng_done_eng = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input int sel, input logic [1:0] a, input logic [31:0] exp, input string name);
    sb.push_back('{sel: sel, exp: exp, name: name});
    address    = a;
    chipselect = (sel == C_RD);
    chk_vld    = 1'b1;
    tick();
    chk_vld    = 1'b0;
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick();
    n_tests++;
    if (busy) begin
      n_fail++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", max);
    end
  endtask

  initial begin
    // Reset values, observed while reset is held
    idle(2);
    chk(C_BUSY, 2'd0, 32'd0,    "rst_busy");
    chk(C_IRQ,  2'd0, 32'd0,    "rst_irq");
    chk(C_RD,   2'd0, 32'd0,    "rst_control");
    chk(C_RD,   2'd1, 32'd0,    "rst_status");
    chk(C_RD,   2'd2, 32'd1000, "rst_timeout");
    chk(C_RD,   2'd3, 32'd0,    "rst_last");
    reset_n = 1'b1;
    idle(2);

    // Basic operation: done 5 cycles after start
    eng_delay = 5;
    wr(2'd0, 32'h3);
    chk(C_ST, 2'd0, 32'd1, "t1_start_pulse");
    wait_idle(100);
    chk(C_RD,  2'd1, 32'h2, "t1_status");
    chk(C_IRQ, 2'd0, 32'd1, "t1_irq");
    chk(C_RD,  2'd3, 32'd5, "t1_last");
    chk(C_NST, 2'd0, 32'd1, "t1_nstarts");
    chk(C_RD,  2'd0, 32'h2, "t1_control");
    wr(2'd1, 32'h2);
    chk(C_RD,  2'd1, 32'h0, "t1_status_clr");
    chk(C_IRQ, 2'd0, 32'd0, "t1_irq_clr");

    // Timeout at 10 counted cycles
    wr(2'd2, 32'd10);
    chk(C_RD, 2'd2, 32'd10, "t2_timeout_rd");
    eng_delay = 0;
    wr(2'd0, 32'h3);
    chk(C_BUSY, 2'd0, 32'd1, "t2_busy_s0");
    idle(8);
    chk(C_BUSY, 2'd0, 32'd1, "t2_busy_s9");
    chk(C_BUSY, 2'd0, 32'd1, "t2_busy_s10");
    chk(C_AB,   2'd0, 32'd1, "t2_abort_pulse");
    chk(C_AB,   2'd0, 32'd0, "t2_abort_one_cycle");
    chk(C_BUSY, 2'd0, 32'd0, "t2_busy_end");
    chk(C_RD,   2'd1, 32'h4, "t2_status");
    chk(C_RD,   2'd3, 32'd5, "t2_last_kept");
    chk(C_NAB,  2'd0, 32'd1, "t2_naborts");
    chk(C_IRQ,  2'd0, 32'd1, "t2_irq");
    wr(2'd1, 32'h1E);

    // Overrun: second GO two cycles after the first
    wr(2'd2, 32'd1000);
    eng_delay = 5;
    wr(2'd0, 32'h3);
    idle(1);
    wr(2'd0, 32'h3);
    wait_idle(100);
    chk(C_RD,  2'd1, 32'h12, "t3_status");
    chk(C_NST, 2'd0, 32'd3,  "t3_nstarts");
    chk(C_RD,  2'd3, 32'd5,  "t3_last");
    chk(C_NAB, 2'd0, 32'd1,  "t3_naborts");
    wr(2'd1, 32'h1E);

    // Abort and done in the same WAIT cycle
    eng_delay = 0;
    wr(2'd0, 32'h3);
    idle(1);
    chipselect   = 1'b1;
    write_n      = 1'b0;
    address      = 2'd0;
    writedata    = 32'h4;
    eng_done_man = 1'b1;
    tick();
    chipselect   = 1'b0;
    write_n      = 1'b1;
    eng_done_man = 1'b0;
    chk(C_AB,   2'd0, 32'd1, "t4_abort_pulse");
    chk(C_BUSY, 2'd0, 32'd0, "t4_busy");
    chk(C_RD,   2'd1, 32'h8, "t4_status");
    chk(C_NAB,  2'd0, 32'd2, "t4_naborts");
    chk(C_RD,   2'd0, 32'h0, "t4_control");
    chk(C_RD,   2'd3, 32'd5, "t4_last");
    chk(C_IRQ,  2'd0, 32'd0, "t4_irq");
    chk(C_NST,  2'd0, 32'd4, "t4_nstarts");
    wr(2'd1, 32'h1E);

    // Timeout disabled, counter saturates
    wr(2'd2, 32'd0);
    eng_delay = 70000;
    wr(2'd0, 32'h3);
    wait_idle(71000);
    chk(C_RD,  2'd1, 32'h2,    "t5_status");
    chk(C_RD,  2'd3, 32'hFFFF, "t5_last_sat");
    chk(C_IRQ, 2'd0, 32'd1,    "t5_irq");
    chk(C_NAB, 2'd0, 32'd2,    "t5_naborts");

    // Reset during WAIT
    wr(2'd2, 32'd500);
    eng_delay = 0;
    wr(2'd0, 32'h3);
    idle(3);
    reset_n = 1'b0;
    chk(C_BUSY, 2'd0, 32'd0,    "t6_busy");
    chk(C_ST,   2'd0, 32'd0,    "t6_start");
    chk(C_AB,   2'd0, 32'd0,    "t6_abort");
    chk(C_IRQ,  2'd0, 32'd0,    "t6_irq");
    chk(C_RD,   2'd2, 32'd1000, "t6_timeout");
    chk(C_RD,   2'd1, 32'd0,    "t6_status");
    chk(C_RD,   2'd3, 32'd0,    "t6_last");
    reset_n = 1'b1;
    idle(3);
    chk(C_NAB, 2'd0, 32'd2, "t6_naborts");
    chk(C_NST, 2'd0, 32'd6, "t6_nstarts");

    idle(2);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
